// File: rtl/int_issue_buffer_if.sv
// ============================================================================
// Module      : int_issue_buffer_if
// Description : Dispatch, wakeup and issue bundle of the integer issue buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface int_issue_buffer_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6,
    parameter int CNT_W = 16
);
    logic             enq;
    logic [XLEN-1:0]  data_in;
    logic [TAG_W-1:0] src1_tag;
    logic             src1_rdy;
    logic [TAG_W-1:0] src2_tag;
    logic             src2_rdy;
    logic [TAG_W-1:0] dst_tag;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic             ready_i;
    logic             full;
    logic             empty;
    logic             issue_valid_o;
    logic [XLEN-1:0]  data_out;
    logic [TAG_W-1:0] issue_dst_o;
    logic [CNT_W-1:0] issued_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport slave (
        input  enq, data_in, src1_tag, src1_rdy, src2_tag, src2_rdy, dst_tag,
               wb_valid, wb_tag, ready_i,
        output full, empty, issue_valid_o, data_out, issue_dst_o,
               issued_cnt_o, stall_cnt_o
    );

    modport master (
        output enq, data_in, src1_tag, src1_rdy, src2_tag, src2_rdy, dst_tag,
               wb_valid, wb_tag, ready_i,
        input  full, empty, issue_valid_o, data_out, issue_dst_o,
               issued_cnt_o, stall_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/int_issue_buffer.sv
// ============================================================================
// Module      : int_issue_buffer
// Description : Collapsing integer-ALU issue queue with result-bus wakeup and
//               oldest-ready-first issue. Define IQ_PERF_EN for perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_issue_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int TAG_W = 6,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    int_issue_buffer_if.slave     bus
);
    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic             v;
        logic [XLEN-1:0]  instr;
        logic [TAG_W-1:0] t1;
        logic             r1;
        logic [TAG_W-1:0] t2;
        logic             r2;
        logic [TAG_W-1:0] dst;
    } entry_t;

    entry_t               ent_q [DEPTH];
    entry_t               ent_d [DEPTH];
    logic [c_CNT_W-1:0]   count_q;
    logic [c_CNT_W-1:0]   count_d;
    logic                 issue_valid_q;
    logic [XLEN-1:0]      data_q;
    logic [TAG_W-1:0]     dst_q;

    logic                 w_found;
    logic [c_IDX_W-1:0]   w_sel;
    logic                 w_issue;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_enq_ok;
    logic [c_IDX_W-1:0]   w_wr_idx;
    entry_t               w_new;

    function automatic entry_t f_wake(input entry_t e, input logic wv,
                                      input logic [TAG_W-1:0] wt);
        entry_t r;
        r = e;
        if (wv && r.v && (r.t1 == wt)) r.r1 = 1'b1;
        if (wv && r.v && (r.t2 == wt)) r.r2 = 1'b1;
        return r;
    endfunction

    assign w_full   = (count_q == c_CNT_W'(DEPTH));
    assign w_empty  = (count_q == '0);
    assign w_issue  = bus.ready_i && w_found;
    assign w_enq_ok = bus.enq && !w_full;
    assign w_wr_idx = c_IDX_W'(count_q - (w_issue ? c_CNT_W'(1) : c_CNT_W'(0)));

    // Lowest ready index is the oldest ready entry because the queue collapses.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].v && ent_q[i].r1 && ent_q[i].r2) begin
                w_found = 1'b1;
                w_sel   = c_IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_new.v     = 1'b1;
        w_new.instr = bus.data_in;
        w_new.t1    = bus.src1_tag;
        w_new.r1    = bus.src1_rdy;
        w_new.t2    = bus.src2_tag;
        w_new.r2    = bus.src2_rdy;
        w_new.dst   = bus.dst_tag;

        for (int i = 0; i < DEPTH - 1; i++) begin
            ent_d[i] = (w_issue && (i >= int'(w_sel))) ? ent_q[i+1] : ent_q[i];
        end
        ent_d[DEPTH-1] = w_issue ? '0 : ent_q[DEPTH-1];

        // Wakeup is applied after the shift so moved entries keep the update.
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = f_wake(ent_d[i], bus.wb_valid, bus.wb_tag);
        end

        if (w_enq_ok) begin
            ent_d[w_wr_idx] = f_wake(w_new, bus.wb_valid, bus.wb_tag);
        end

        count_d = count_q;
        if (w_enq_ok && !w_issue) count_d = count_q + c_CNT_W'(1);
        if (!w_enq_ok && w_issue) count_d = count_q - c_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            data_q        <= '0;
            dst_q         <= '0;
        end else begin
            ent_q         <= ent_d;
            count_q       <= count_d;
            issue_valid_q <= w_issue;
            if (w_issue) begin
                data_q <= ent_q[w_sel].instr;
                dst_q  <= ent_q[w_sel].dst;
            end
        end
    end

    assign bus.full          = w_full;
    assign bus.empty         = w_empty;
    assign bus.issue_valid_o = issue_valid_q;
    assign bus.data_out      = data_q;
    assign bus.issue_dst_o   = dst_q;

`ifdef IQ_PERF_EN
    logic [CNT_W-1:0] issued_q;
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (w_issue) issued_q <= issued_q + CNT_W'(1);
            if (!w_empty && !w_issue) stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign bus.issued_cnt_o = issued_q;
    assign bus.stall_cnt_o  = stall_q;
`else
    assign bus.issued_cnt_o = {CNT_W{1'b0}};
    assign bus.stall_cnt_o  = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_int_issue_buffer.sv
// ============================================================================
// Module      : tb_int_issue_buffer
// Description : Scoreboard bench for int_issue_buffer with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_issue_buffer;
    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam int TAG_W = 6;
    localparam int CNT_W = 16;

    typedef struct {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] dst;
    } exp_t;

    logic clk;
    logic resetn;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    exp_t sbq[$];

    int_issue_buffer_if #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

    int_issue_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else pass_cnt++;
    endtask

    // Monitor: every issue strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn && bus.issue_valid_o) begin
            total_cnt++;
            if (sbq.size() == 0) begin
                $display("FAIL issue_unexpected actual=%0h required=none", bus.data_out);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (bus.data_out !== e.data || bus.issue_dst_o !== e.dst)
                    $display("FAIL issue_data actual=%0h/%0d required=%0h/%0d",
                             bus.data_out, bus.issue_dst_o, e.data, e.dst);
                else pass_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.enq      = 1'b0;
        bus.data_in  = '0;
        bus.src1_tag = '0;
        bus.src1_rdy = 1'b0;
        bus.src2_tag = '0;
        bus.src2_rdy = 1'b0;
        bus.dst_tag  = '0;
        bus.wb_valid = 1'b0;
        bus.wb_tag   = '0;
    endtask

    task automatic push(input logic [XLEN-1:0] d, input logic [TAG_W-1:0] t);
        exp_t e;
        e.data = d;
        e.dst  = t;
        sbq.push_back(e);
    endtask

    task automatic enq1(input logic [XLEN-1:0] d, input logic [TAG_W-1:0] t1, input logic r1,
                        input logic [TAG_W-1:0] t2, input logic r2, input logic [TAG_W-1:0] dst);
        bus.enq      = 1'b1;
        bus.data_in  = d;
        bus.src1_tag = t1;
        bus.src1_rdy = r1;
        bus.src2_tag = t2;
        bus.src2_rdy = r2;
        bus.dst_tag  = dst;
        tick();
        bus.enq      = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n;
        n = 0;
        while (!bus.empty && n < budget) begin
            tick();
            n++;
        end
        if (!bus.empty) begin
            total_cnt++;
            $display("FAIL %s_timeout actual=not_empty required=empty", name);
        end
        tick();
        tick();
    endtask

    task automatic sb_drained(input string name);
        chk(name, 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        idle();
        bus.ready_i = 1'b0;
        resetn      = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // Reset state
        @(negedge clk);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_valid", 64'(bus.issue_valid_o), 64'd0);
        chk("rst_data", 64'(bus.data_out), 64'd0);
        chk("rst_dst", 64'(bus.issue_dst_o), 64'd0);
        chk("rst_cnts", {32'(bus.issued_cnt_o), 32'(bus.stall_cnt_o)}, 64'd0);
        tick();

        // 1: single ready instruction
        bus.ready_i = 1'b1;
        push(32'h0050_0093, 6'd3);
        enq1(32'h0050_0093, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3);
        tick();
        @(negedge clk);
        chk("t1_valid", 64'(bus.issue_valid_o), 64'd1);
        chk("t1_empty", 64'(bus.empty), 64'd1);
        tick();
        sb_drained("t1_drained");

        // 2: younger ready entry bypasses older waiting one; wakeup latency
        push(32'hB000_0002, 6'd11);
        push(32'hA000_0001, 6'd10);
        enq1(32'hA000_0001, 6'd7, 1'b0, 6'd8, 1'b1, 6'd10);
        enq1(32'hB000_0002, 6'd4, 1'b1, 6'd5, 1'b1, 6'd11);
        repeat (3) tick();
        chk("t2_a_waiting", 64'(bus.empty), 64'd0);
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 6'd7;
        tick();
        bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("t2_no_same_cycle", 64'(bus.issue_valid_o), 64'd0);
        tick();
        @(negedge clk);
        chk("t2_a_issued", 64'(bus.issue_valid_o), 64'd1);
        tick();
        sb_drained("t2_drained");

        // 3: fill, overflow enq ignored, back-to-back drain
        bus.ready_i = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            push(32'h3000_0000 + 32'(k), 6'(k + 1));
            enq1(32'h3000_0000 + 32'(k), 6'd1, 1'b1, 6'd2, 1'b1, 6'(k + 1));
        end
        @(negedge clk);
        chk("t3_full", 64'(bus.full), 64'd1);
        enq1(32'hDEAD_BEEF, 6'd1, 1'b1, 6'd2, 1'b1, 6'd63);
        @(negedge clk);
        chk("t3_full_after_ovf", 64'(bus.full), 64'd1);
        bus.ready_i = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("t3_issue%0d", k), 64'(bus.issue_valid_o), 64'd1);
        end
        chk("t3_empty", 64'(bus.empty), 64'd1);
        tick();
        @(negedge clk);
        chk("t3_no_ovf_issue", 64'(bus.issue_valid_o), 64'd0);
        sb_drained("t3_drained");

        // 4: enq+issue when full, then at count 7
        bus.ready_i = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            push(32'h4000_0000 + 32'(k), 6'(k + 20));
            enq1(32'h4000_0000 + 32'(k), 6'd1, 1'b1, 6'd2, 1'b1, 6'(k + 20));
        end
        bus.ready_i = 1'b1;
        enq1(32'h0000_0BAD, 6'd1, 1'b1, 6'd2, 1'b1, 6'd62);
        bus.ready_i = 1'b0;
        @(negedge clk);
        chk("t4_count7_notfull", 64'(bus.full), 64'd0);
        tick();
        bus.ready_i = 1'b1;
        push(32'h4000_0100, 6'd40);
        enq1(32'h4000_0100, 6'd1, 1'b1, 6'd2, 1'b1, 6'd40);
        bus.ready_i = 1'b0;
        @(negedge clk);
        chk("t4_still7", 64'(bus.full), 64'd0);
        tick();
        push(32'h4000_0200, 6'd41);
        enq1(32'h4000_0200, 6'd1, 1'b1, 6'd2, 1'b1, 6'd41);
        @(negedge clk);
        chk("t4_full_again", 64'(bus.full), 64'd1);
        tick();
        bus.ready_i = 1'b1;
        wait_empty("t4", 40);
        sb_drained("t4_drained");

        // 5: same-cycle wakeup of the incoming entry
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 6'd9;
        push(32'h5000_0005, 6'd50);
        enq1(32'h5000_0005, 6'd1, 1'b1, 6'd9, 1'b0, 6'd50);
        bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("t5_not_same_cycle", 64'(bus.issue_valid_o), 64'd0);
        tick();
        @(negedge clk);
        chk("t5_issued", 64'(bus.issue_valid_o), 64'd1);
        tick();
        sb_drained("t5_drained");

        // 6: asynchronous reset mid-stream
        bus.ready_i = 1'b0;
        for (int k = 0; k < 5; k++) enq1(32'h6000_0000 + 32'(k), 6'd1, 1'b1, 6'd2, 1'b1, 6'd5);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_empty", 64'(bus.empty), 64'd1);
        chk("t6_valid", 64'(bus.issue_valid_o), 64'd0);
        chk("t6_cnts", {32'(bus.issued_cnt_o), 32'(bus.stall_cnt_o)}, 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        push(32'h6100_0001, 6'd33);
        enq1(32'h6100_0001, 6'd1, 1'b1, 6'd2, 1'b1, 6'd33);
        repeat (3) tick();
        bus.ready_i = 1'b1;
        tick();
        @(negedge clk);
`ifdef IQ_PERF_EN
        chk("t6_issued_cnt", 64'(bus.issued_cnt_o), 64'd1);
        chk("t6_stall_cnt", 64'(bus.stall_cnt_o), 64'd3);
`else
        chk("t6_issued_cnt", 64'(bus.issued_cnt_o), 64'd0);
        chk("t6_stall_cnt", 64'(bus.stall_cnt_o), 64'd0);
`endif
        tick();
        chk("t6_final_empty", 64'(bus.empty), 64'd1);
        sb_drained("t6_drained");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
